// File: rtl/minisys_ctrl_pkg.sv
// minisys_ctrl_pkg: shared encodings for the Minisys multi-cycle controller.
// Holds the FSM state enum, the opcode/funct codes the controller decodes,
// the HI_LO_move encoding and the access-size codes taken from opcode[1:0].
package minisys_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_MULDIV = 3'd6
   } state_t;

   // Full opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   // Opcode groups on op[5:3]
   localparam logic [2:0] OPG_IFMT  = 3'b001;
   localparam logic [2:0] OPG_LOAD  = 3'b100;
   localparam logic [2:0] OPG_STORE = 3'b101;

   // R-type funct codes
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MTHI = 6'b010001;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MTLO = 6'b010011;
   // mult/multu/div/divu share funct[5:2]
   localparam logic [3:0] FN_MULDIV_TOP = 4'b0110;

   // HI_LO_move encoding
   localparam logic [1:0] HLM_NONE = 2'b00;
   localparam logic [1:0] HLM_HI   = 2'b10;
   localparam logic [1:0] HLM_LO   = 2'b01;

   // Access size from op[1:0]; anything else is treated as a word
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

endpackage

// File: rtl/byte_lane_gen.sv
// byte_lane_gen: byte-lane write enables and misalignment flag for a
// load/store of the given size at byte offset addr_lo_i. A misaligned
// access never produces any lane enable.
module byte_lane_gen
   import minisys_ctrl_pkg::*;
(
   input  logic [1:0] size_i,
   input  logic [1:0] addr_lo_i,
   output logic [3:0] lanes_o,
   output logic       misaligned_o
);

   // Lane and alignment decode per access size
   always_comb begin
      lanes_o      = 4'b0000;
      misaligned_o = 1'b0;
      case (size_i)
         SZ_BYTE: lanes_o = 4'b0001 << addr_lo_i;
         SZ_HALF: begin
            misaligned_o = addr_lo_i[0];
            if (!addr_lo_i[0]) lanes_o = 4'b0011 << {addr_lo_i[1], 1'b0};
         end
         default: begin
            misaligned_o = (addr_lo_i != 2'b00);
            if (addr_lo_i == 2'b00) lanes_o = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control32.sv
// multicycle_control32: multi-cycle controller for the Minisys CPU.
// Latches the instruction into IR and sequences FETCH/DECODE/EXEC/MEM/WB,
// with wait states on mem_ready and a fixed-length MULDIV stall.
// Build option: define MEM_TIMEOUT_EN to bound mem_ready waits in FETCH/MEM
// to TIMEOUT_CYCLES cycles (abort with addr_err, no PCWrite).
module multicycle_control32
   import minisys_ctrl_pkg::*;
#(
   parameter int                   IO_HIGH_W      = 22,
   parameter logic [IO_HIGH_W-1:0] IO_HIGH_VAL    = {IO_HIGH_W{1'b1}},
   parameter int                   MULDIV_CYCLES  = 32,
   parameter int                   TIMEOUT_CYCLES = 255
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [31:0]          Instruction,
   input  logic [IO_HIGH_W-1:0] ALUResultHigh,
   input  logic [1:0]           addr_lo,
   input  logic                 mem_ready,
   output logic                 fetch_req,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegDST,
   output logic                 ALUSrc,
   output logic                 RegWrite,
   output logic                 MemOrIOtoReg,
   output logic                 Branch,
   output logic                 nBranch,
   output logic                 Jmp,
   output logic                 Jal,
   output logic                 Jr,
   output logic [1:0]           ALUOp,
   output logic                 Sftmd,
   output logic                 I_format,
   output logic                 MemRead,
   output logic                 IORead,
   output logic                 IOWrite,
   output logic [3:0]           MemWrite,
   output logic                 Do_signed,
   output logic                 HI_LO_write,
   output logic [1:0]           HI_LO_move,
   output logic                 md_start,
   output logic                 addr_err,
   output logic                 retired,
   output logic                 busy,
   output logic [2:0]           dbg_state_o
);

   localparam int              MD_W    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
   localparam logic [MD_W-1:0] MD_LAST = MD_W'(MULDIV_CYCLES - 1);

   state_t          state_q, state_d;
   logic [31:0]     ir_q;
   logic [MD_W-1:0] md_cnt_q, md_cnt_d;
   logic            md_last;
   logic            timeout_hit;

   // Instruction class decode, from the latched IR only
   logic [5:0] op, funct;
   logic       is_r, is_i, is_load, is_store, is_mem, is_beq, is_bne, is_j, is_jal;
   logic       is_jr, is_md, is_mthi, is_mtlo, is_mfhi, is_mflo, is_io;
   logic [3:0] lanes;
   logic       mis_raw, misaligned;
   logic       unused_ir_bits;

   assign op             = ir_q[31:26];
   assign funct          = ir_q[5:0];
   assign unused_ir_bits = ^ir_q[25:6];
   assign is_r      = (op == OP_RTYPE);
   assign is_i      = (op[5:3] == OPG_IFMT);
   assign is_load   = (op[5:3] == OPG_LOAD);
   assign is_store  = (op[5:3] == OPG_STORE);
   assign is_mem    = is_load | is_store;
   assign is_beq    = (op == OP_BEQ);
   assign is_bne    = (op == OP_BNE);
   assign is_j      = (op == OP_J);
   assign is_jal    = (op == OP_JAL);
   assign is_jr     = is_r && (funct == FN_JR);
   assign is_md     = is_r && (funct[5:2] == FN_MULDIV_TOP);
   assign is_mthi   = is_r && (funct == FN_MTHI);
   assign is_mtlo   = is_r && (funct == FN_MTLO);
   assign is_mfhi   = is_r && (funct == FN_MFHI);
   assign is_mflo   = is_r && (funct == FN_MFLO);
   assign is_io     = (ALUResultHigh == IO_HIGH_VAL);

   byte_lane_gen u_lanes (
      .size_i       (op[1:0]),
      .addr_lo_i    (addr_lo),
      .lanes_o      (lanes),
      .misaligned_o (mis_raw)
   );
   assign misaligned = is_mem && mis_raw;

   assign md_last  = (md_cnt_q == MD_LAST);
   assign md_cnt_d = (state_q == S_MULDIV && !md_last) ? md_cnt_q + MD_W'(1) : '0;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       waiting;

   // A wait cycle never changes state, so the counter only survives while stalled
   assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM && !misaligned)) && !mem_ready;
   assign timeout_hit = waiting && (to_cnt_q == TO_LAST);
   assign to_cnt_d    = (waiting && !timeout_hit) ? to_cnt_q + 8'd1 : 8'd0;

   // Wait-cycle counter register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) to_cnt_q <= 8'd0;
      else          to_cnt_q <= to_cnt_d;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   // State, IR and MULDIV counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ir_q     <= 32'd0;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         if (IRWrite) ir_q <= Instruction;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (is_mem)     state_d = S_MEM;
            else if (is_md) state_d = S_MULDIV;
            else            state_d = S_EXEC;
         end
         S_EXEC:   state_d = S_FETCH;
         S_MULDIV: if (md_last) state_d = S_FETCH;
         S_MEM: begin
            if (misaligned || timeout_hit) state_d = S_FETCH;
            else if (mem_ready)            state_d = is_load ? S_WB : S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode from state and IR
   always_comb begin
      fetch_req    = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegDST       = 1'b0;
      ALUSrc       = 1'b0;
      RegWrite     = 1'b0;
      MemOrIOtoReg = 1'b0;
      Branch       = 1'b0;
      nBranch      = 1'b0;
      Jmp          = 1'b0;
      Jal          = 1'b0;
      Jr           = 1'b0;
      ALUOp        = 2'b00;
      Sftmd        = 1'b0;
      I_format     = 1'b0;
      MemRead      = 1'b0;
      IORead       = 1'b0;
      IOWrite      = 1'b0;
      MemWrite     = 4'b0000;
      Do_signed    = 1'b0;
      HI_LO_write  = 1'b0;
      HI_LO_move   = HLM_NONE;
      md_start     = 1'b0;
      addr_err     = 1'b0;
      retired      = 1'b0;
      busy         = (state_q != S_IDLE);
      case (state_q)
         S_FETCH: begin
            fetch_req = !timeout_hit;
            IRWrite   = mem_ready;
            addr_err  = timeout_hit;
         end
         S_DECODE: md_start = is_md;
         S_EXEC: begin
            RegDST   = is_r;
            ALUSrc   = is_i;
            I_format = is_i;
            ALUOp    = {is_r | is_i, is_beq | is_bne};
            Sftmd    = is_r && (funct[5:3] == 3'b000);
            Branch   = is_beq;
            nBranch  = is_bne;
            Jmp      = is_j;
            Jal      = is_jal;
            Jr       = is_jr;
            RegWrite = (is_r && !is_jr && !is_mthi && !is_mtlo) || is_i || is_jal;
            if (is_mfhi)      HI_LO_move = HLM_HI;
            else if (is_mflo) HI_LO_move = HLM_LO;
            PCWrite  = 1'b1;
            retired  = 1'b1;
         end
         S_MULDIV: begin
            HI_LO_write = md_last;
            PCWrite     = md_last;
            retired     = md_last;
         end
         S_MEM: begin
            ALUSrc = 1'b1;
            if (misaligned) begin
               addr_err = 1'b1;
               PCWrite  = 1'b1;
            end else if (timeout_hit) begin
               addr_err = 1'b1;
            end else begin
               MemRead  = is_load && !is_io;
               IORead   = is_load && is_io;
               IOWrite  = is_store && is_io;
               MemWrite = (is_store && !is_io) ? lanes : 4'b0000;
               PCWrite  = is_store && mem_ready;
               retired  = is_store && mem_ready;
            end
         end
         S_WB: begin
            ALUSrc       = 1'b1;
            RegWrite     = 1'b1;
            MemOrIOtoReg = 1'b1;
            Do_signed    = !op[2] && !op[1];
            PCWrite      = 1'b1;
            retired      = 1'b1;
         end
         default: ;
      endcase
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_control32.sv
// tb_multicycle_control32: directed/random bench for multicycle_control32
// with MULDIV_CYCLES=4. Every PCWrite cycle is matched against a queue of
// expected commit signatures {retired,RegWrite,RegDST,MemOrIOtoReg,
// Do_signed,addr_err,HI_LO_write} pushed by the stimulus tasks.
module tb_multicycle_control32;
   import minisys_ctrl_pkg::*;

   localparam int W = 7;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] Instruction = 32'd0;
   logic [21:0] ALUResultHigh = 22'd0;
   logic [1:0]  addr_lo = 2'd0;
   logic        mem_ready = 1'b0;
   logic        fetch_req, IRWrite, PCWrite, RegDST, ALUSrc, RegWrite, MemOrIOtoReg;
   logic        Branch, nBranch, Jmp, Jal, Jr, Sftmd, I_format, MemRead, IORead, IOWrite;
   logic        Do_signed, HI_LO_write, md_start, addr_err, retired, busy;
   logic [1:0]  ALUOp, HI_LO_move;
   logic [3:0]  MemWrite;
   logic [2:0]  dbg_state;
   logic [30:0] all_out;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_got, mon_exp;
   int checks = 0;
   int failures = 0;

   multicycle_control32 #(.MULDIV_CYCLES(4)) dut (
      .clock(clock), .reset_n(reset_n), .Instruction(Instruction),
      .ALUResultHigh(ALUResultHigh), .addr_lo(addr_lo), .mem_ready(mem_ready),
      .fetch_req(fetch_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDST(RegDST),
      .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemOrIOtoReg(MemOrIOtoReg),
      .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
      .ALUOp(ALUOp), .Sftmd(Sftmd), .I_format(I_format), .MemRead(MemRead),
      .IORead(IORead), .IOWrite(IOWrite), .MemWrite(MemWrite), .Do_signed(Do_signed),
      .HI_LO_write(HI_LO_write), .HI_LO_move(HI_LO_move), .md_start(md_start),
      .addr_err(addr_err), .retired(retired), .busy(busy), .dbg_state_o(dbg_state)
   );

   assign all_out = {fetch_req, IRWrite, PCWrite, RegDST, ALUSrc, RegWrite, MemOrIOtoReg,
                     Branch, nBranch, Jmp, Jal, Jr, ALUOp, Sftmd, I_format, MemRead,
                     IORead, IOWrite, MemWrite, Do_signed, HI_LO_write, HI_LO_move,
                     md_start, addr_err, retired, busy};

   // Clock
   always #5 clock = ~clock;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Scoreboard: every commit (PCWrite) pops one expected signature
   always @(negedge clock) begin
      #1;
      if (PCWrite === 1'b1) begin
         mon_got = {retired, RegWrite, RegDST, MemOrIOtoReg, Do_signed, addr_err, HI_LO_write};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL commit_sb: unexpected commit got=%b state=%0d", mon_got, dbg_state);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL commit_sb: got=%b exp=%b", mon_got, mon_exp);
            end
         end
      end
   end

   // Driver: fetch one instruction after 'waits' not-ready cycles; returns in DECODE
   task automatic fetch_instr(input logic [31:0] instr, input int waits);
      Instruction = instr;
      mem_ready   = 1'b0;
      repeat (waits) @(negedge clock);
      mem_ready = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (all_out !== 31'd0 || dbg_state !== S_IDLE) begin
         failures++;
         $display("FAIL reset_outputs: got=%h state=%0d exp=0 state=0", all_out, dbg_state);
      end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if (all_out !== 31'd0 || dbg_state !== S_IDLE) begin
         failures++;
         $display("FAIL reset_release_idle: got=%h state=%0d", all_out, dbg_state);
      end
      @(negedge clock);
      #1;
      checks++;
      if ({fetch_req, IRWrite, busy} !== 3'b101 || dbg_state !== S_FETCH) begin
         failures++;
         $display("FAIL reset_to_fetch: got=%b state=%0d exp=101 state=%0d",
                  {fetch_req, IRWrite, busy}, dbg_state, S_FETCH);
      end
   endtask

   task automatic test_fetch_wait();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({fetch_req, IRWrite, busy} !== 3'b101 || dbg_state !== S_FETCH) begin
            failures++;
            $display("FAIL fetch_wait[%0d]: got=%b state=%0d exp=101", i,
                     {fetch_req, IRWrite, busy}, dbg_state);
         end
         @(negedge clock);
         #1;
      end
   endtask

   // EXEC-path instructions; vector = {RW,RD,ALUSrc,I_fmt,Br,nBr,Jmp,Jal,Jr,Sftmd,ALUOp,HLM}
   task automatic test_exec_ops();
      logic [31:0] instr [11] = '{32'h00221821, 32'h34220055, 32'h10220004, 32'h14220004,
                                  32'h08000010, 32'h0C000010, 32'h03E00008, 32'h00002010,
                                  32'h00002012, 32'h000110C0, 32'hFC000000};
      logic [13:0] exp_v [11] = '{{10'b1100000000, 2'b10, 2'b00}, {10'b1011000000, 2'b10, 2'b00},
                                  {10'b0000100000, 2'b01, 2'b00}, {10'b0000010000, 2'b01, 2'b00},
                                  {10'b0000001000, 2'b00, 2'b00}, {10'b1000000100, 2'b00, 2'b00},
                                  {10'b0100000010, 2'b10, 2'b00}, {10'b1100000000, 2'b10, 2'b10},
                                  {10'b1100000000, 2'b10, 2'b01}, {10'b1100000001, 2'b10, 2'b00},
                                  {10'b0000000000, 2'b00, 2'b00}};
      logic [13:0] got_v;
      for (int i = 0; i < 11; i++) begin
         fetch_instr(instr[i], (i == 0) ? 0 : int'($urandom_range(0, 3)));
         exp_q.push_back({1'b1, exp_v[i][13], exp_v[i][12], 4'b0000});
         checks++;
         if (dbg_state !== S_DECODE || {PCWrite, RegWrite, md_start, retired, MemWrite} !== 8'd0) begin
            failures++;
            $display("FAIL decode[%0d]: state=%0d strobes=%b exp state=%0d strobes=0", i,
                     dbg_state, {PCWrite, RegWrite, md_start, retired, MemWrite}, S_DECODE);
         end
         @(negedge clock);
         #1;
         got_v = {RegWrite, RegDST, ALUSrc, I_format, Branch, nBranch, Jmp, Jal, Jr, Sftmd,
                  ALUOp, HI_LO_move};
         checks++;
         if (got_v !== exp_v[i] || {PCWrite, retired} !== 2'b11 || dbg_state !== S_EXEC) begin
            failures++;
            $display("FAIL exec[%0d]: got=%b pc_ret=%b state=%0d exp=%b pc_ret=11", i,
                     got_v, {PCWrite, retired}, dbg_state, exp_v[i]);
         end
         @(negedge clock);
         #1;
      end
   endtask

   task automatic test_sb_wait();
      fetch_instr(32'hA0220002, 0);
      exp_q.push_back(7'b1000000);
      addr_lo       = 2'd2;
      ALUResultHigh = 22'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         mem_ready = (i == 3);
         #1;
         checks++;
         if (MemWrite !== 4'b0100 || PCWrite !== (i == 3) || dbg_state !== S_MEM) begin
            failures++;
            $display("FAIL sb_wait[%0d]: MemWrite=%b PCWrite=%b state=%0d exp=0100 %0d", i,
                     MemWrite, PCWrite, dbg_state, (i == 3));
         end
      end
      @(negedge clock);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (dbg_state !== S_FETCH || MemWrite !== 4'b0000) begin
         failures++;
         $display("FAIL sb_wait_done: state=%0d MemWrite=%b exp state=%0d", dbg_state, MemWrite, S_FETCH);
      end
   endtask

   task automatic test_store_lanes();
      logic [31:0] instr [7] = '{32'hA0220000, 32'hA0220000, 32'hA4220000, 32'hA4220000,
                                 32'hAC220000, 32'hAC220000, 32'hA0220000};
      logic [1:0]  al [7]    = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
      logic        io [7]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0]  lanes [7] = '{4'b0001, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000, 4'b0000};
      for (int i = 0; i < 7; i++) begin
         fetch_instr(instr[i], int'($urandom_range(0, 2)));
         exp_q.push_back(7'b1000000);
         addr_lo       = al[i];
         ALUResultHigh = io[i] ? 22'h3FFFFF : 22'($urandom_range(0, 32'h3FFFFE));
         mem_ready     = 1'b1;
         @(negedge clock);
         #1;
         checks++;
         if ({MemWrite, IOWrite, MemRead, IORead, addr_err} !== {lanes[i], io[i], 3'b000}) begin
            failures++;
            $display("FAIL store_lanes[%0d]: got=%b exp=%b", i,
                     {MemWrite, IOWrite, MemRead, IORead, addr_err}, {lanes[i], io[i], 3'b000});
         end
         @(negedge clock);
         mem_ready = 1'b0;
         #1;
      end
   endtask

   task automatic test_loads();
      logic [31:0] instr [5] = '{32'h8C220000, 32'h80220003, 32'h90220000, 32'h84220000, 32'h94220000};
      logic [1:0]  al [5]    = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
      logic        io [5]    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        sg [5]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int          waits [5] = '{2, 0, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
         fetch_instr(instr[i], 0);
         exp_q.push_back({4'b1101, sg[i], 2'b00});
         addr_lo       = al[i];
         ALUResultHigh = io[i] ? 22'h3FFFFF : 22'h000155;
         for (int w = 0; w <= waits[i]; w++) begin
            @(negedge clock);
            mem_ready = (w == waits[i]);
            #1;
            checks++;
            if ({MemRead, IORead, MemWrite, IOWrite, PCWrite} !== {!io[i], io[i], 6'd0} ||
                dbg_state !== S_MEM) begin
               failures++;
               $display("FAIL load_mem[%0d]: got=%b state=%0d exp=%b", i,
                        {MemRead, IORead, MemWrite, IOWrite, PCWrite}, dbg_state, {!io[i], io[i], 6'd0});
            end
         end
         @(negedge clock);
         mem_ready = 1'b0;
         #1;
         checks++;
         if ({RegWrite, MemOrIOtoReg, Do_signed, PCWrite, retired, RegDST, MemRead, IORead} !==
             {2'b11, sg[i], 5'b11000} || dbg_state !== S_WB) begin
            failures++;
            $display("FAIL load_wb[%0d]: got=%b state=%0d exp=%b", i,
                     {RegWrite, MemOrIOtoReg, Do_signed, PCWrite, retired, RegDST, MemRead, IORead},
                     dbg_state, {2'b11, sg[i], 5'b11000});
         end
         @(negedge clock);
         #1;
      end
   endtask

   task automatic test_muldiv();
      logic [31:0] instr [2] = '{32'h00220018, 32'h0022001B};
      for (int i = 0; i < 2; i++) begin
         fetch_instr(instr[i], 0);
         exp_q.push_back(7'b1000001);
         checks++;
         if ({md_start, busy, HI_LO_write} !== 3'b110 || dbg_state !== S_DECODE) begin
            failures++;
            $display("FAIL md_start[%0d]: got=%b state=%0d exp=110", i,
                     {md_start, busy, HI_LO_write}, dbg_state);
         end
         for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            #1;
            checks++;
            if ({HI_LO_write, PCWrite, retired} !== ((k == 4) ? 3'b111 : 3'b000) ||
                {busy, md_start} !== 2'b10 || dbg_state !== S_MULDIV) begin
               failures++;
               $display("FAIL muldiv[%0d] cycle %0d: got=%b busy=%b state=%0d", i, k,
                        {HI_LO_write, PCWrite, retired}, busy, dbg_state);
            end
         end
         @(negedge clock);
         #1;
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] instr [4] = '{32'hA4220001, 32'hAC220002, 32'h8C220003, 32'h84220001};
      logic [1:0]  al [4]    = '{2'd1, 2'd2, 2'd3, 2'd1};
      for (int i = 0; i < 4; i++) begin
         fetch_instr(instr[i], 0);
         exp_q.push_back(7'b0000010);
         addr_lo       = al[i];
         ALUResultHigh = 22'd0;
         mem_ready     = 1'($urandom_range(0, 1));
         @(negedge clock);
         #1;
         checks++;
         if ({MemWrite, MemRead, IORead, IOWrite, addr_err, PCWrite, retired} !== 10'b0000000110) begin
            failures++;
            $display("FAIL misaligned[%0d]: got=%b exp=0000000110", i,
                     {MemWrite, MemRead, IORead, IOWrite, addr_err, PCWrite, retired});
         end
         @(negedge clock);
         mem_ready = 1'b0;
         #1;
         checks++;
         if (dbg_state !== S_FETCH || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_next[%0d]: state=%0d addr_err=%b exp state=%0d", i,
                     dbg_state, addr_err, S_FETCH);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      fetch_instr(32'hAC220000, 0);
      addr_lo       = 2'd0;
      ALUResultHigh = 22'd0;
      @(negedge clock);
      #1;
      checks++;
      if (MemWrite !== 4'b1111 || dbg_state !== S_MEM) begin
         failures++;
         $display("FAIL sw_mem: MemWrite=%b state=%0d exp=1111", MemWrite, dbg_state);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (all_out !== 31'd0 || dbg_state !== S_IDLE) begin
         failures++;
         $display("FAIL async_reset: got=%h state=%0d exp=0", all_out, dbg_state);
      end
      mem_ready = 1'b1;
      @(negedge clock);
      #1;
      checks++;
      if (all_out !== 31'd0) begin
         failures++;
         $display("FAIL reset_hold: got=%h exp=0", all_out);
      end
      mem_ready = 1'b0;
      reset_n   = 1'b1;
      @(negedge clock);
      #1;
      checks++;
      if (dbg_state !== S_FETCH || fetch_req !== 1'b1) begin
         failures++;
         $display("FAIL reset_restart: state=%0d fetch_req=%b exp state=%0d", dbg_state, fetch_req, S_FETCH);
      end
      fetch_instr(32'h00221821, 1);
      exp_q.push_back(7'b1110000);
      @(negedge clock);
      #1;
      checks++;
      if ({RegWrite, RegDST, retired} !== 3'b111 || dbg_state !== S_EXEC) begin
         failures++;
         $display("FAIL post_reset_exec: got=%b state=%0d exp=111", {RegWrite, RegDST, retired}, dbg_state);
      end
      @(negedge clock);
      #1;
   endtask

   initial begin
      test_reset();
      test_fetch_wait();
      test_exec_ops();
      test_sb_wait();
      test_store_lanes();
      test_loads();
      test_muldiv();
      test_misaligned();
      test_reset_mid_mem();
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL commit_drain: %0d expected commits never seen, exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
